// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake, flush, and kill counter.
//
// Carries one control+data payload per transfer between two pipeline stages. A stage can
// stall through the handshake, so no global enables are needed. Flush kills every stored
// entry and the payload offered in that cycle. Whenever out_valid is low, out_ctrl and
// out_data are zero, so an empty stage reads as a NOP bubble.
//
// Build option:
//   PIPE_STAGE_REG_SKID_EN  defined   -> 2-entry skid buffer; in_ready comes from a flop.
//                           undefined -> single register; in_ready is combinational
//                                        from out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous kill of stored entries and of the current input
//   in_valid   upstream offers a payload
//   in_ready   stage accepts a payload this cycle
//   in_ctrl    incoming control field (CTRL_W)
//   in_data    incoming data field (DATA_W)
//   out_valid  head entry is valid
//   out_ready  downstream consumes the head entry this cycle
//   out_ctrl   head control field, zero when out_valid is low
//   out_data   head data field, zero when out_valid is low
//   occupancy  number of stored valid entries (0..2)
//   kill_cnt   saturating count of valid entries discarded by flush (CNT_W)
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  kill_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic accept;
  logic deliver;

  assign accept  = in_valid && in_ready && !flush;
  assign deliver = out_valid && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  // Skid is only ever occupied while main is occupied, and in_ready_q is low whenever
  // both are full, so accept and a full skid never coincide.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      skid_data_d  = '0;
    end else if (deliver) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
        skid_data_d  = '0;
      end else if (accept) begin
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        // Clear the payload so the drained stage presents a zero bubble.
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
        main_data_d  = '0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end
    // Registered ready: it tracks next-cycle occupancy < 2, with no path from out_ready.
    in_ready_d = !(main_valid_d && skid_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
`else
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (deliver) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign occupancy = {1'b0, valid_q};
`endif

  // Kill counter: entries held minus the one delivered, plus the offered payload.
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
  logic [2:0]       kill_inc;
  logic [CNT_W+1:0] kill_sum;

  always_comb begin
    kill_inc   = {1'b0, occupancy} - {2'b00, deliver} + {2'b00, in_valid};
    kill_sum   = {2'b00, kill_cnt_q} + (CNT_W+2)'(kill_inc);
    kill_cnt_d = kill_cnt_q;
    if (flush) begin
      if (kill_sum > {2'b00, CntMax}) begin
        kill_cnt_d = CntMax;
      end else begin
        kill_cnt_d = kill_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_cnt_q <= '0;
    end else begin
      kill_cnt_q <= kill_cnt_d;
    end
  end

  assign kill_cnt = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with a 2-bit counter checks saturation.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] kill_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [63:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_kill_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .kill_cnt  (kill_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (s_out_ctrl),
    .out_data  (s_out_data),
    .occupancy (s_occupancy),
    .kill_cnt  (s_kill_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] c, input logic [63:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_occ",      64'(occupancy), 64'd0);
    chk("rst_valid",    64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready),  64'd1);
    chk("rst_kill",     64'(kill_cnt),  64'd0);
    rst_n = 1'b1;
    tick();

    // Fill the stage while stalled, then reset asynchronously mid-cycle.
    offer(8'h11, 64'hAA);
    tick();
    chk("fill_data",  out_data, 64'hAA);
    offer(8'h22, 64'hBB);
    tick();
    chk("fill_occ",   64'(occupancy), Skid ? 64'd2 : 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ctrl",  64'(out_ctrl),  64'd0);
    chk("arst_data",  out_data,       64'd0);
    chk("arst_occ",   64'(occupancy), 64'd0);
    chk("arst_kill",  64'(kill_cnt),  64'd0);
    chk("arst_ready", 64'(in_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming with out_ready high: one-cycle latency, one per cycle, in order.
    out_ready = 1'b1;
    offer(8'h5A, 64'h1234);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_ctrl",  64'(out_ctrl),  64'h5A);
    chk("lat_data",  out_data,       64'h1234);
    for (int i = 1; i <= 3; i++) begin
      offer(8'(i), 64'(i));
      tick();
      chk("stream_data",  out_data,       64'(i));
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl",  64'(out_ctrl),  64'd0);
    chk("bubble_data",  out_data,       64'd0);

    // Stall behaviour.
    out_ready = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
    offer(8'h0A, 64'hA0);
    tick();
    chk("skid_ready_a", 64'(in_ready), 64'd1);
    offer(8'h0B, 64'hB0);
    tick();
    chk("skid_ready_b", 64'(in_ready),  64'd0);
    chk("skid_occ",     64'(occupancy), 64'd2);
    chk("skid_hold_a",  out_data,       64'hA0);
    offer(8'h0C, 64'hC0);
    tick();
    chk("skid_hold2_a", out_data,       64'hA0);
    chk("skid_occ2",    64'(occupancy), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("skid_out_b",   out_data,       64'hB0);
    tick();
    chk("skid_out_c",   out_data,       64'hC0);
    chk("skid_ctrl_c",  64'(out_ctrl),  64'h0C);
    in_valid = 1'b0;
    tick();
    chk("skid_drain",   64'(out_valid), 64'd0);
`else
    offer(8'h0A, 64'hA0);
    tick();
    offer(8'h0B, 64'hB0);
    #1;
    chk("single_stall_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("single_comb_ready",  64'(in_ready), 64'd1);
    tick();
    chk("single_out_b",  out_data,       64'hB0);
    chk("single_occ",    64'(occupancy), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("single_drain",  64'(out_valid), 64'd0);
`endif

    // Flush with a full stage and a payload offered in the same cycle.
    out_ready = 1'b0;
    offer(8'h31, 64'h310);
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    offer(8'h32, 64'h320);
    tick();
`endif
    offer(8'hDD, 64'hDEAD);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl",  64'(out_ctrl),  64'd0);
    chk("flush_data",  out_data,       64'd0);
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_kill",  64'(kill_cnt),  Skid ? 64'd3 : 64'd2);
    chk("flush_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    tick();
    chk("flush_no_leak", 64'(out_valid), 64'd0);

    // Counter clears on reset only; then four single-entry flushes saturate the 2-bit one.
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("sat_rst_big",   64'(kill_cnt),   64'd0);
    chk("sat_rst_small", 64'(s_kill_cnt), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      offer(8'(8'h40 + i), 64'(i));
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_small", 64'(s_kill_cnt), (i > 3) ? 64'd3 : 64'(i));
      chk("sat_big",   64'(kill_cnt),   64'(i));
    end

    // Flush while the held entry is delivered: nothing counts as killed.
    offer(8'h77, 64'h77);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_deliver_kill", 64'(kill_cnt),  64'd4);
    chk("flush_deliver_occ",  64'(occupancy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-stage latch registers between pipeline stages (ID/EX, EX/MEM, MEM/WB). Carries one payload word (control + data fields) per transfer with a valid/ready handshake, so a stage can stall without global enables. A synchronous flush kills in-flight entries and emits NOP bubbles with all control bits zero. A saturating counter reports how many valid entries were killed by flushes.

## Interface
- DATA_W, 64, width of the data field (operands, PC, immediates, packed by the instantiating stage)
- CTRL_W, 8, width of the control field (WB/MEM enables, branch, S, EXE command…); forced to zero in every bubble
- CNT_W, 16, width of the kill counter
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all stored entries and of the current input
- in_valid  input  1  upstream has a payload
- in_ready  output  1  stage accepts a payload this cycle
- in_ctrl  input  CTRL_W  incoming control field
- in_data  input  DATA_W  incoming data field
- out_valid  output  1  head entry is valid
- out_ready  input  1  downstream consumes head entry this cycle
- out_ctrl  output  CTRL_W  head control field; 0 when out_valid=0
- out_data  output  DATA_W  head data field; 0 when out_valid=0
- occupancy  output  2  number of stored valid entries (0..2)
- kill_cnt  output  CNT_W  saturating count of valid entries discarded by flush

## Operation
- Accept: in_valid && in_ready && !flush. Deliver: out_valid && out_ready. Both may fire in one cycle.
- Entries leave in acceptance order. No payload is ever duplicated or dropped except by flush.
- Bubble rule: whenever out_valid=0, out_ctrl and out_data are all-zero.
- Single-entry mode (no macro): one register. in_ready = (occupancy==0) || out_ready. This path is combinational from out_ready. occupancy ∈ {0,1}.
- Skid mode (macro defined): main + skid register. in_ready = (occupancy<2), driven from a flop with no combinational path from out_ready. If the main register is full, out_ready=0 and an accept occurs, the payload goes to skid. On the next deliver, skid moves to main.
- Flush: takes priority over accept/deliver. Next cycle occupancy=0, out_valid=0, outputs zero. A payload offered during the flush cycle is discarded (in_ready may read 1; no transfer). A deliver in the flush cycle still counts as consumed by downstream.
- kill_cnt: on flush, adds the entries held that cycle minus any delivered that cycle, plus 1 if in_valid=1. Saturates at 2^CNT_W−1 and never wraps.
- in_valid=1 with flush=0 and in_ready=0: upstream must hold its payload stable. The block does not check this.

## Timing
- Reset (rst_n low, asynchronous): occupancy=0, out_valid=0, out_ctrl=0, out_data=0, kill_cnt=0, in_ready=1. Release takes effect on the first clk edge with rst_n high.
- Latency: a payload accepted at edge N appears on out_* after edge N (1 cycle), in both modes.
- Throughput: 1 transfer/cycle when out_ready stays high.
- Stall: out_ready low holds out_* stable. Single mode stops accepting at 1 entry; skid mode accepts one more, then drops in_ready the following cycle.
- Empty + accept + out_ready: the output is valid next cycle; there is no bypass in the same cycle.
- Flush and reset mid-transfer: entries are cleared; the counter increments only for flush, never for reset.

## Configuration
- PIPE_STAGE_REG_SKID_EN defined: 2-entry skid mode. in_ready is registered, which breaks the ready timing path across stages.
- Undefined: single-entry mode. in_ready is combinational from out_ready. Minimum area.

## Test plan
- Reset then stream: assert rst_n low mid-stream with 2 entries held → all outputs 0 and kill_cnt=0 immediately. Then in_valid=1 with ctrl=0x5A, data=0x1234 and out_ready=1 → out_valid=1, out_ctrl=0x5A, out_data=0x1234 one cycle later; back-to-back payloads 1,2,3 emerge 1/cycle in order.
- Stall, skid mode: hold out_ready=0 and offer A, B, C → A and B accepted, in_ready=0 from the cycle after B, occupancy=2, out_data=A held. Release out_ready → A, B, C delivered in order with no gap.
- Stall, single mode: out_ready=0 with A stored → in_ready=0. Raise out_ready with B offered → A delivered and B accepted in the same cycle.
- Flush: occupancy=2 plus in_valid=1 with flush=1 → next cycle out_valid=0, out_ctrl=0, out_data=0, kill_cnt=3. The offered payload never appears at the output.
- Saturation: CNT_W=2, drive four flushes with 1 entry each → kill_cnt reads 1, 2, 3, 3.
- Bubble check: out_valid=0 after a deliver drains the stage → out_ctrl=0 and out_data=0 in the same cycle out_valid falls.
